// File: rtl/map_index_to_display_stepper_if.sv
// rtl/map_index_to_display_stepper_if.sv - target index handshake into the display stepper
interface map_index_to_display_stepper_if;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [6:0] tgt_idx_x;
   logic [5:0] tgt_idx_y;

   modport master (output tgt_valid, output tgt_idx_x, output tgt_idx_y, input tgt_ready);
   modport slave  (input tgt_valid, input tgt_idx_x, input tgt_idx_y, output tgt_ready);
endinterface

// File: rtl/map_index_to_display_stepper.sv
// rtl/map_index_to_display_stepper.sv - walks sprite display position toward a target map index
// Optional: define MAP_STEPPER_RETARGET_EN to accept new targets while moving.
module map_index_to_display_stepper #(
   parameter int H_VISIBLE_START = 336,
   parameter int V_VISIBLE_START = 27,
   parameter int SCALE_LOG2      = 4,
   parameter int MOVE_TO_CENTER  = 7,
   parameter int MAP_W           = 80,
   parameter int MAP_H           = 60,
   parameter int RESET_IDX_X     = 40,
   parameter int RESET_IDX_Y     = 45,
   parameter int STEP_PX         = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 move_tick,
   map_index_to_display_stepper_if.slave        tgt,
   output logic [10:0]                          disp_pos_x,
   output logic [9:0]                           disp_pos_y,
   output logic [3:0]                           moving_dir,
   output logic                                 busy,
   output logic                                 arrived
);

`ifdef MAP_STEPPER_RETARGET_EN
   localparam bit RETARGET = 1'b1;
`else
   localparam bit RETARGET = 1'b0;
`endif

   localparam logic [10:0] RESET_PIX_X =
      11'((RESET_IDX_X << SCALE_LOG2) + MOVE_TO_CENTER + H_VISIBLE_START);
   localparam logic [9:0]  RESET_PIX_Y =
      10'((RESET_IDX_Y << SCALE_LOG2) + MOVE_TO_CENTER + V_VISIBLE_START);

   localparam logic [3:0] DIR_R = 4'b0001;
   localparam logic [3:0] DIR_L = 4'b0010;
   localparam logic [3:0] DIR_U = 4'b0100;
   localparam logic [3:0] DIR_D = 4'b1000;

   typedef enum logic {IDLE, MOVE} state_t;

   state_t      state;
   logic [10:0] pos_x, tgt_x, new_x, eff_x, dist_x, step_x, nxt_x;
   logic [9:0]  pos_y, tgt_y, new_y, eff_y, dist_y, step_y, nxt_y;
   logic [3:0]  dir_q, nxt_dir;
   logic [6:0]  clamp_x;
   logic [5:0]  clamp_y;
   logic        ready_q, accept;

   assign tgt.tgt_ready = ready_q;
   assign accept        = tgt.tgt_valid && ready_q;
   assign disp_pos_x    = pos_x;
   assign disp_pos_y    = pos_y;
   assign moving_dir    = dir_q;

   // Sum formed at full width, then truncated to the display coordinate width.
   always_comb begin
      clamp_x = (tgt.tgt_idx_x > 7'(MAP_W - 1)) ? 7'(MAP_W - 1) : tgt.tgt_idx_x;
      clamp_y = (tgt.tgt_idx_y > 6'(MAP_H - 1)) ? 6'(MAP_H - 1) : tgt.tgt_idx_y;
      new_x   = 11'((12'(clamp_x) << SCALE_LOG2) + 12'(MOVE_TO_CENTER) + 12'(H_VISIBLE_START));
      new_y   = 10'((11'(clamp_y) << SCALE_LOG2) + 11'(MOVE_TO_CENTER) + 11'(V_VISIBLE_START));
   end

   // A target accepted during MOVE steers the step taken on the same edge.
   always_comb begin
      eff_x  = accept ? new_x : tgt_x;
      eff_y  = accept ? new_y : tgt_y;
      dist_x = (eff_x > pos_x) ? eff_x - pos_x : pos_x - eff_x;
      dist_y = (eff_y > pos_y) ? eff_y - pos_y : pos_y - eff_y;
      step_x = (dist_x < 11'(STEP_PX)) ? dist_x : 11'(STEP_PX);
      step_y = (dist_y < 10'(STEP_PX)) ? dist_y : 10'(STEP_PX);
   end

   always_comb begin
      nxt_x   = pos_x;
      nxt_y   = pos_y;
      nxt_dir = dir_q;
      if (move_tick) begin
         if (pos_x != eff_x) begin
            if (eff_x > pos_x) begin
               nxt_x   = pos_x + step_x;
               nxt_dir = DIR_R;
            end else begin
               nxt_x   = pos_x - step_x;
               nxt_dir = DIR_L;
            end
         end else if (pos_y != eff_y) begin
            if (eff_y > pos_y) begin
               nxt_y   = pos_y + step_y;
               nxt_dir = DIR_D;
            end else begin
               nxt_y   = pos_y - step_y;
               nxt_dir = DIR_U;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pos_x   <= RESET_PIX_X;
         pos_y   <= RESET_PIX_Y;
         tgt_x   <= RESET_PIX_X;
         tgt_y   <= RESET_PIX_Y;
         dir_q   <= DIR_R;
         busy    <= 1'b0;
         arrived <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         arrived <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  tgt_x <= new_x;
                  tgt_y <= new_y;
                  if (new_x == pos_x && new_y == pos_y) begin
                     arrived <= 1'b1;
                  end else begin
                     state   <= MOVE;
                     busy    <= 1'b1;
                     ready_q <= RETARGET;
                  end
               end
            end
            MOVE: begin
               if (accept) begin
                  tgt_x <= new_x;
                  tgt_y <= new_y;
               end
               pos_x <= nxt_x;
               pos_y <= nxt_y;
               dir_q <= nxt_dir;
               if (nxt_x == eff_x && nxt_y == eff_y) begin
                  arrived <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_map_index_to_display_stepper.sv
// tb/tb_map_index_to_display_stepper.sv - randomized model-checked bench for the display stepper
module tb_map_index_to_display_stepper;

`ifdef MAP_STEPPER_RETARGET_EN
   localparam bit RETARGET = 1'b1;
`else
   localparam bit RETARGET = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        move_tick = 1'b0;
   logic [10:0] disp_pos_x;
   logic [9:0]  disp_pos_y;
   logic [3:0]  moving_dir;
   logic        busy, arrived;

   map_index_to_display_stepper_if tif ();

   map_index_to_display_stepper dut (
      .clk        (clk),
      .rst        (rst),
      .move_tick  (move_tick),
      .tgt        (tif.slave),
      .disp_pos_x (disp_pos_x),
      .disp_pos_y (disp_pos_y),
      .moving_dir (moving_dir),
      .busy       (busy),
      .arrived    (arrived)
   );

   always #5 clk = ~clk;

   int  checks = 0;
   int  errors = 0;
   int  arr_cnt = 0;
   bit  chk_en = 1'b0;

   // Reference: position in pixels, a target and whether a move is in flight.
   int  m_x, m_y, m_tx, m_ty, m_dir;
   bit  m_active, m_arr, m_acc;

   function automatic int pix_x(int ix);
      return ((ix > 79) ? 79 : ix) * 16 + 7 + 336;
   endfunction

   function automatic int pix_y(int iy);
      return ((iy > 59) ? 59 : iy) * 16 + 7 + 27;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_x = 983; m_y = 754; m_tx = 983; m_ty = 754;
         m_dir = 1; m_active = 0; m_arr = 0;
      end else begin
         m_arr = 0;
         m_acc = tif.tgt_valid && (RETARGET || !m_active);
         if (m_acc) begin
            m_tx = pix_x(int'(tif.tgt_idx_x));
            m_ty = pix_y(int'(tif.tgt_idx_y));
         end
         if (!m_active) begin
            if (m_acc) begin
               if (m_tx == m_x && m_ty == m_y) m_arr = 1;
               else m_active = 1;
            end
         end else begin
            if (move_tick) begin
               if (m_x != m_tx) begin
                  m_dir = (m_tx > m_x) ? 1 : 2;
                  m_x   = m_x + ((m_tx > m_x) ? 1 : -1);
               end else if (m_y != m_ty) begin
                  m_dir = (m_ty > m_y) ? 8 : 4;
                  m_y   = m_y + ((m_ty > m_y) ? 1 : -1);
               end
            end
            if (m_x == m_tx && m_y == m_ty) begin
               m_arr = 1;
               m_active = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst && chk_en) begin
         checks++;
         if (int'(disp_pos_x) != m_x || int'(disp_pos_y) != m_y || int'(moving_dir) != m_dir ||
             busy != m_active || arrived != m_arr || tif.tgt_ready != (RETARGET || !m_active)) begin
            errors++;
            $display("FAIL model t=%0t actual pos=(%0d,%0d) dir=%b busy=%b arr=%b rdy=%b required pos=(%0d,%0d) dir=%0d busy=%b arr=%b rdy=%b",
                     $time, disp_pos_x, disp_pos_y, moving_dir, busy, arrived, tif.tgt_ready,
                     m_x, m_y, m_dir, m_active, m_arr, (RETARGET || !m_active));
         end
      end
      if (rst && arrived) arr_cnt++;
   end

   task automatic check_eq(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      move_tick = 1'b0;
      tif.tgt_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic present(int ix, int iy);
      tif.tgt_valid = 1'b1;
      tif.tgt_idx_x = 7'(ix);
      tif.tgt_idx_y = 6'(iy);
      @(negedge clk);
      tif.tgt_valid = 1'b0;
   endtask

   task automatic wait_arrived(string name, output int n);
      n = 0;
      while (!arrived && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!arrived) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_arrival required=arrival", name);
      end
   endtask

   int n, a0;

   initial begin
      tif.tgt_valid = 1'b0;
      tif.tgt_idx_x = '0;
      tif.tgt_idx_y = '0;

      // 1: reset state
      do_reset();
      chk_en = 1'b1;
      check_eq("rst_x", int'(disp_pos_x), 983);
      check_eq("rst_y", int'(disp_pos_y), 754);
      check_eq("rst_dir", int'(moving_dir), 1);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_ready", int'(tif.tgt_ready), 1);

      // 2: 32 steps right
      move_tick = 1'b1;
      present(42, 45);
      wait_arrived("t2", n);
      check_eq("t2_steps", n, 32);
      check_eq("t2_x", int'(disp_pos_x), 1015);
      check_eq("t2_dir", int'(moving_dir), 1);
      @(negedge clk);
      check_eq("t2_pulse", int'(arrived), 0);

      // 3: right then down
      do_reset();
      move_tick = 1'b1;
      present(41, 46);
      wait_arrived("t3", n);
      check_eq("t3_steps", n, 32);
      check_eq("t3_x", int'(disp_pos_x), 999);
      check_eq("t3_y", int'(disp_pos_y), 770);
      check_eq("t3_dir", int'(moving_dir), 8);

      // 4: clamped column
      do_reset();
      move_tick = 1'b1;
      present(127, 45);
      wait_arrived("t4", n);
      check_eq("t4_steps", n, 624);
      check_eq("t4_x", int'(disp_pos_x), 1607);
      repeat (3) @(negedge clk);
      check_eq("t4_hold_x", int'(disp_pos_x), 1607);

      // 5: target equals current position
      do_reset();
      move_tick = 1'b1;
      present(40, 45);
      check_eq("t5_arrived", int'(arrived), 1);
      check_eq("t5_busy", int'(busy), 0);

      // 6: retarget mid-move
      do_reset();
      move_tick = 1'b1;
      a0 = arr_cnt;
      present(42, 45);
      repeat (5) @(negedge clk);
      check_eq("t6_mid_x", int'(disp_pos_x), 988);
      present(40, 44);
      wait_arrived("t6", n);
      if (RETARGET) begin
         check_eq("t6_x", int'(disp_pos_x), 983);
         check_eq("t6_y", int'(disp_pos_y), 738);
         check_eq("t6_dir", int'(moving_dir), 4);
      end else begin
         check_eq("t6_x", int'(disp_pos_x), 1015);
         check_eq("t6_y", int'(disp_pos_y), 754);
      end
      repeat (3) @(negedge clk);
      check_eq("t6_arrivals", arr_cnt - a0, 1);

      // Randomized traffic checked against the model every cycle
      do_reset();
      for (int i = 0; i < 8000; i++) begin
         tif.tgt_valid = ($urandom_range(0, 7) == 0);
         tif.tgt_idx_x = ($urandom_range(0, 15) == 0) ? 7'd127 : 7'($urandom_range(36, 46));
         tif.tgt_idx_y = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(41, 49));
         move_tick = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1999) == 0) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
         @(negedge clk);
      end
      tif.tgt_valid = 1'b0;
      move_tick = 1'b1;
      repeat (2000) @(negedge clk);
      check_eq("drain_busy", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
